// File: rtl/seq_mul_unit.sv
// Iterative radix-2 shift-add multiplier (signed/unsigned) built around one DW-bit adder.
// Define SEQ_MUL_EARLY_OUT_EN to leave RUN as soon as the remaining multiplier bits are zero.
module seq_mul_unit #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          op_signed_i,
   input  logic          kill_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] prod_hi_o,
   output logic [DW-1:0] prod_lo_o
);

   localparam int unsigned CW = $clog2(DW + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] mcand_q, mcand_d;
   logic [DW-1:0] mplier_q, mplier_d;
   logic [DW-1:0] acc_hi_q, acc_hi_d;
   logic [DW-1:0] acc_lo_q, acc_lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic          sgn_q, sgn_d;
   logic          fix_ph_q, fix_ph_d;
   logic          fix_c_q, fix_c_d;
   logic [DW-1:0] prod_hi_q, prod_hi_d;
   logic [DW-1:0] prod_lo_q, prod_lo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [DW-1:0] add_a, add_b, add_sum;
   logic          add_cin, add_co;

   // The single shared adder
   assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (DW + 1)'(add_cin);

   // Adder operand mux; the start cycle uses the idle adder to take |b| of the incoming operand
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            add_a   = ~b_i;
            add_cin = 1'b1;
         end
         S_ABS: begin
            add_a   = ~mcand_q;
            add_cin = 1'b1;
         end
         S_RUN: begin
            add_a = acc_hi_q;
            add_b = mplier_q[0] ? mcand_q : '0;
         end
         S_FIX: begin
            add_a   = fix_ph_q ? ~acc_hi_q : ~acc_lo_q;
            add_cin = fix_ph_q ? fix_c_q : 1'b1;
         end
         default: ;
      endcase
   end

`ifdef SEQ_MUL_EARLY_OUT_EN
   logic [2*DW-1:0] eo_shift;
`endif

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      sgn_d     = sgn_q;
      fix_ph_d  = fix_ph_q;
      fix_c_d   = fix_c_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
`ifdef SEQ_MUL_EARLY_OUT_EN
      eo_shift  = (2 * DW)'({add_co, add_sum, acc_lo_q} >> cnt_q);
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               mcand_d  = a_i;
               mplier_d = (op_signed_i & b_i[DW-1]) ? add_sum : b_i;
               sgn_d    = op_signed_i;
               neg_d    = op_signed_i & (a_i[DW-1] ^ b_i[DW-1]);
               state_d  = S_ABS;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_ABS: begin
            if (sgn_q & mcand_q[DW-1]) mcand_d = add_sum;
            acc_hi_d = '0;
            acc_lo_d = '0;
            cnt_d    = CW'(DW);
            fix_ph_d = 1'b0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            acc_hi_d = {add_co, add_sum[DW-1:1]};
            acc_lo_d = {add_sum[0], acc_lo_q[DW-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
`ifdef SEQ_MUL_EARLY_OUT_EN
            // Remaining steps would only add zero: align in one shift by the remaining count
            if (mplier_q[DW-1:1] == '0) begin
               {acc_hi_d, acc_lo_d} = eo_shift;
               state_d = S_FIX;
            end
`endif
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!fix_ph_q) begin
               if (neg_q) begin
                  acc_lo_d = add_sum;
                  fix_c_d  = add_co;
               end
               fix_ph_d = 1'b1;
            end else begin
               if (neg_q) acc_hi_d = add_sum;
               prod_hi_d = neg_q ? add_sum : acc_hi_q;
               prod_lo_d = acc_lo_q;
               fix_ph_d  = 1'b0;
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over everything, including a same-cycle start and the result write
      if (kill_i) begin
         state_d   = S_IDLE;
         prod_hi_d = prod_hi_q;
         prod_lo_d = prod_lo_q;
      end
      busy_d = state_d inside {S_ABS, S_RUN, S_FIX};
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         fix_ph_q  <= 1'b0;
         fix_c_q   <= 1'b0;
         prod_hi_q <= '0;
         prod_lo_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         sgn_q     <= sgn_d;
         fix_ph_q  <= fix_ph_d;
         fix_c_q   <= fix_c_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign prod_hi_o = prod_hi_q;
   assign prod_lo_o = prod_lo_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: vector table, random ops vs. arithmetic model, control corners.
module tb_seq_mul_unit;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, op_signed, kill;
   logic [DW-1:0] a, b;
   logic          busy, done;
   logic [DW-1:0] prod_hi, prod_lo;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_mul_unit #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .op_signed_i(op_signed),
      .kill_i     (kill),
      .a_i        (a),
      .b_i        (b),
      .busy_o     (busy),
      .done_o     (done),
      .prod_hi_o  (prod_hi),
      .prod_lo_o  (prod_lo)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
      end
   endtask

   // Reference product from plain 64-bit arithmetic
   function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic signed [63:0] sx, sy;
      if (s) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         return 64'(sx * sy);
      end
      return {32'h0, x} * {32'h0, y};
   endfunction

   // Cycles from the start cycle to the done cycle
   function automatic int ref_lat(input logic [31:0] y, input logic s);
      logic [31:0] mag;
      int top;
      mag = (s && y[31]) ? (32'd0 - y) : y;
      top = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) top = i + 1;
`ifndef SEQ_MUL_EARLY_OUT_EN
      top = int'(DW);
`endif
      return 4 + ((top < 1) ? 1 : top);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output logic [63:0] got, output int lat);
      a = x; b = y; op_signed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check("busy_after_start", 64'(busy), 64'(1'b1));
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
      end
      got = {prod_hi, prod_lo};
   endtask

   initial begin
      logic [63:0] got, prev;
      int lat, ndone, done_at;
      logic [31:0] ra, rb;
      logic rs;

      vecs[0] = '{32'd7,         32'd6,         1'b0, 32'h00000000, 32'h0000002A};
      vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{32'hFFFFFFFD,  32'h00000005,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[3] = '{32'h80000000,  32'h80000000,  1'b1, 32'h40000000, 32'h00000000};
      vecs[4] = '{32'h00000000,  32'hFFFFFFFD,  1'b1, 32'h00000000, 32'h00000000};
      vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h00000000, 32'h00000001};
      vecs[6] = '{32'h80000000,  32'h00000001,  1'b1, 32'hFFFFFFFF, 32'h80000000};
      vecs[7] = '{32'd9,         32'd3,         1'b0, 32'h00000000, 32'h0000001B};

      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op_signed = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(1'b0));
      check("reset_done", 64'(done), 64'(1'b0));
      check("reset_prod", {prod_hi, prod_lo}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].s, got, lat);
         check("vec_prod", got, {vecs[i].hi, vecs[i].lo});
         check("vec_latency", 64'(lat), 64'(ref_lat(vecs[i].b, vecs[i].s)));
         check("vec_busy_at_done", 64'(busy), 64'(1'b0));
         @(negedge clk);
         check("vec_done_one_cycle", 64'(done), 64'(1'b0));
      end

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         rs = 1'($urandom_range(0, 1));
         do_op(ra, rb, rs, got, lat);
         check("rand_prod", got, ref_prod(ra, rb, rs));
         check("rand_latency", 64'(lat), 64'(ref_lat(rb, rs)));
         @(negedge clk);
      end

      // Back-to-back issue straight from DONE
      do_op(32'd100, 32'd200, 1'b0, got, lat);
      check("b2b_first", got, 64'd20000);
      do_op(32'hFFFFFFFD, 32'd5, 1'b1, got, lat);
      check("b2b_second", got, ref_prod(32'hFFFFFFFD, 32'd5, 1'b1));
      check("b2b_latency", 64'(lat), 64'(ref_lat(32'd5, 1'b1)));
      prev = got;

      // Start while busy is ignored
      @(negedge clk);
      a = 32'h00012345; b = 32'h80000001; op_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; done_at = 0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 10) begin a = 32'hDEAD; b = 32'd7; op_signed = 1'b1; start = 1'b1; end
         if (c == 11) start = 1'b0;
         if (c == 20) check("prod_held_while_busy", {prod_hi, prod_lo}, prev);
         if (done) begin ndone++; done_at = c; got = {prod_hi, prod_lo}; end
         @(negedge clk);
      end
      check("ignored_start_one_done", 64'(ndone), 64'd1);
      check("ignored_start_latency", 64'(done_at), 64'(ref_lat(32'h80000001, 1'b0)));
      check("ignored_start_prod", got, ref_prod(32'h00012345, 32'h80000001, 1'b0));

      // Asynchronous reset mid-operation
      a = 32'd5; b = 32'hF0000000; op_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'(1'b0));
      check("rst_mid_done", 64'(done), 64'(1'b0));
      check("rst_mid_prod", {prod_hi, prod_lo}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_busy", 64'(busy), 64'(1'b0));
      do_op(32'h00001234, 32'hC0000000, 1'b0, got, lat);
      check("post_reset_prod", got, ref_prod(32'h00001234, 32'hC0000000, 1'b0));
      prev = got;

      // Kill mid-operation, then kill together with start
      @(negedge clk);
      a = 32'h0000BEEF; b = 32'hC0000000; op_signed = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", 64'(busy), 64'(1'b0));
      a = 32'd3; b = 32'd3; op_signed = 1'b0; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill_beats_start_busy", 64'(busy), 64'(1'b0));
      ndone = 0;
      for (int c = 0; c < 50; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("kill_no_done", 64'(ndone), 64'd0);
      check("kill_prod_kept", {prod_hi, prod_lo}, prev);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
